pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush scheduler for the five-stage MIPS pipeline with precise interrupts.
- Combines three inputs into per-cycle enables and flushes for the F/D pipeline register and the D/E bubble insertion:
  - the D-stage data-hazard request (Tuse/Tnew compare);
  - a multi-cycle HI/LO multiply/divide busy model;
  - interrupt and ERET redirection.
- Also drives PC-source selects and keeps a saturating stall-cycle performance counter.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu start.
- DIV_CYCLES, 10, busy cycles after a div/divu start.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- D_stall_data  in  1  data-hazard stall request from the D-stage Tuse/Tnew compare.
- D_is_md  in  1  instruction in D uses the HI/LO unit (mult/div/mfhi/mflo/mthi/mtlo).
- D_eret  in  1  instruction in D is eret.
- E_md_start  in  1  mult/div starts in E this cycle.
- E_md_div  in  1  qualifies E_md_start: 1 = div/divu, 0 = mult/multu.
- intReq  in  1  interrupt/exception accepted by CP0 this cycle.
- F_en  out  1  PC / F_Reg write enable.
- D_en  out  1  F/D register write enable.
- E_flush  out  1  load a nop into E (bubble).
- pc_sel_exc  out  1  next PC = 0x0000_4180.
- pc_sel_epc  out  1  next PC = EPC.
- md_busy  out  1  HI/LO unit busy.
- md_count  out  5  remaining busy cycles.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset (async, immediate): state=RUN, md_count=0, stall_cnt=0.
- Outputs while reset is high: F_en=1, D_en=1, E_flush=0, pc_sel_exc=0, pc_sel_epc=0, md_busy=0.
- Outputs are combinational from state, md_count and inputs (zero-latency). md_count, state and stall_cnt are registers.
- md_busy = (md_count != 0).
- Multiply/divide counter:
  - E_md_start & ~intReq loads MULT_CYCLES or DIV_CYCLES (selected by E_md_div).
  - Otherwise, if md_count != 0, md_count decrements by 1.
  - intReq does not abort a running count; the HI/LO unit completes independently.
  - A start while busy reloads (cannot occur legally; behaviour defined anyway).
- stall = D_stall_data | (D_is_md & (md_busy | E_md_start)).
- FSM states: RUN, ERET_FLUSH.
- Priority each cycle: intReq > ERET_FLUSH action > stall > normal.
  - intReq (any state):
    - F_en=1, D_en=1, E_flush=1, pc_sel_exc=1, pc_sel_epc=0.
    - next state RUN.
    - stall is ignored and not counted.
    - F/D register self-clears on intReq.
  - ERET_FLUSH (no intReq):
    - F_en=1, D_en=1, E_flush=1, pc_sel_* = 0.
    - Squashes the wrong-path instruction fetched after eret.
    - stall ignored; next state RUN.
  - RUN with stall:
    - F_en=0, D_en=0, E_flush=1, pc_sel_* = 0.
    - stall_cnt += 1, saturating at all-ones.
    - eret in D is not acted on until the stall clears.
  - RUN, no stall, D_eret:
    - F_en=1, D_en=1, E_flush=0, pc_sel_epc=1.
    - next state ERET_FLUSH.
  - RUN, otherwise: F_en=1, D_en=1, E_flush=0, pc_sel_* = 0.
- pc_sel_exc and pc_sel_epc are never both 1.
- Reset mid-operation clears md_count and state on the same edge reset rises (asynchronous); outputs return to reset values immediately.

Test Plan:
- Reset with D_stall_data=1: F_en=1, D_en=1, E_flush=0, stall_cnt=0 while reset is high. After release: F_en=0, D_en=0, E_flush=1, stall_cnt increments to 1 after the next edge.
- E_md_start=1, E_md_div=0 at cycle 0, then D_is_md=1 held:
  - md_count reads 5,4,3,2,1,0 on the following edges;
  - stall asserted cycles 0..5;
  - stall_cnt=6 when D_is_md drops with md_count=0.
- E_md_start=1, E_md_div=1 together with intReq=1: md_count stays 0 and pc_sel_exc=1. Repeat with intReq during an active div: counting continues to 0.
- D_eret=1 in RUN, no stall:
  - cycle N: pc_sel_epc=1;
  - cycle N+1: state ERET_FLUSH with E_flush=1, F_en=1, D_en=1, pc_sel_epc=0;
  - cycle N+2: RUN.
- D_eret=1 with D_stall_data=1 for 2 cycles: pc_sel_epc=0 during the stall, pc_sel_epc=1 on the third cycle. Then intReq=1 in ERET_FLUSH: pc_sel_exc=1, next state RUN.
- Force stall for 2^CNT_W + 3 cycles: stall_cnt saturates at 0xFFFF (CNT_W=16) and does not wrap.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the five-stage MIPS pipeline: merges data hazards,
// the HI/LO busy model and interrupt/ERET redirection into pipeline enables.
module pipe_hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             D_stall_data,
    input  logic             D_is_md,
    input  logic             D_eret,
    input  logic             E_md_start,
    input  logic             E_md_div,
    input  logic             intReq,
    output logic             F_en,
    output logic             D_en,
    output logic             E_flush,
    output logic             pc_sel_exc,
    output logic             pc_sel_epc,
    output logic             md_busy,
    output logic [4:0]       md_count,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic {
        RUN        = 1'b0,
        ERET_FLUSH = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [4:0]       r_md_count;
    logic [4:0]       w_md_count_next;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_md_busy;
    logic             w_stall;
    logic             w_count_stall;

    assign w_md_busy = (r_md_count != 5'd0);
    assign w_stall   = D_stall_data | (D_is_md & (w_md_busy | E_md_start));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Priority: interrupt, then the post-ERET squash, then stall, then ERET issue.
    always_comb begin
        w_state_next  = r_state;
        F_en          = 1'b1;
        D_en          = 1'b1;
        E_flush       = 1'b0;
        pc_sel_exc    = 1'b0;
        pc_sel_epc    = 1'b0;
        w_count_stall = 1'b0;
        if (reset) begin
            w_state_next = RUN;
        end else if (intReq) begin
            E_flush      = 1'b1;
            pc_sel_exc   = 1'b1;
            w_state_next = RUN;
        end else if (r_state == ERET_FLUSH) begin
            E_flush      = 1'b1;
            w_state_next = RUN;
        end else if (w_stall) begin
            F_en          = 1'b0;
            D_en          = 1'b0;
            E_flush       = 1'b1;
            w_count_stall = 1'b1;
        end else if (D_eret) begin
            pc_sel_epc   = 1'b1;
            w_state_next = ERET_FLUSH;
        end
    end

    // The HI/LO unit keeps counting through an interrupt; only a start is suppressed.
    always_comb begin
        w_md_count_next = r_md_count;
        if (E_md_start && !intReq) begin
            w_md_count_next = E_md_div ? 5'(DIV_CYCLES) : 5'(MULT_CYCLES);
        end else if (w_md_busy) begin
            w_md_count_next = r_md_count - 5'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_md_count <= 5'd0;
        end else begin
            r_md_count <= w_md_count_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_count_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign md_busy   = w_md_busy & ~reset;
    assign md_count  = r_md_count;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random
// traffic, all compared against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W   = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             D_stall_data, D_is_md, D_eret, E_md_start, E_md_div, intReq;
    logic             F_en, D_en, E_flush, pc_sel_exc, pc_sel_epc, md_busy;
    logic [4:0]       md_count;
    logic [CNT_W-1:0] stall_cnt;

    int n_total = 0;
    int n_pass  = 0;

    // Model state: remaining HI/LO cycles, "squash slot pending" flag, stall tally.
    int m_md   = 0;
    bit m_sq   = 0;
    int m_cnt  = 0;

    pipe_hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .D_stall_data(D_stall_data), .D_is_md(D_is_md), .D_eret(D_eret),
        .E_md_start(E_md_start), .E_md_div(E_md_div), .intReq(intReq),
        .F_en(F_en), .D_en(D_en), .E_flush(E_flush),
        .pc_sel_exc(pc_sel_exc), .pc_sel_epc(pc_sel_epc),
        .md_busy(md_busy), .md_count(md_count), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp_v, $time);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".F_en"}, 32'(F_en), 1);
        chk({tag, ".D_en"}, 32'(D_en), 1);
        chk({tag, ".E_flush"}, 32'(E_flush), 0);
        chk({tag, ".exc"}, 32'(pc_sel_exc), 0);
        chk({tag, ".epc"}, 32'(pc_sel_epc), 0);
        chk({tag, ".busy"}, 32'(md_busy), 0);
        chk({tag, ".md_count"}, 32'(md_count), 0);
        chk({tag, ".stall_cnt"}, 32'(stall_cnt), 0);
    endtask

    // Entered just after a rising edge: apply inputs, check at the falling edge,
    // then advance the model across the next rising edge.
    task automatic cycle(input string tag, input bit sd, input bit md, input bit er,
                         input bit st, input bit dv, input bit ir, input bit verbose);
        bit e_f, e_d, e_fl, e_x, e_p, stall;
        D_stall_data = sd; D_is_md = md; D_eret = er;
        E_md_start = st; E_md_div = dv; intReq = ir;
        stall = sd || (md && (m_md > 0 || st));
        e_f = 1; e_d = 1; e_fl = 0; e_x = 0; e_p = 0;
        @(negedge clk);
        chk({tag, ".md_count"}, 32'(md_count), 32'(m_md));
        chk({tag, ".busy"}, 32'(md_busy), 32'(m_md > 0));
        chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_cnt));
        if (ir) begin
            e_fl = 1; e_x = 1; m_sq = 0;
        end else if (m_sq) begin
            e_fl = 1; m_sq = 0;
        end else if (stall) begin
            e_f = 0; e_d = 0; e_fl = 1;
            if (m_cnt < CNT_MAX) m_cnt++;
        end else if (er) begin
            e_p = 1; m_sq = 1;
        end
        chk({tag, ".F_en"}, 32'(F_en), 32'(e_f));
        chk({tag, ".D_en"}, 32'(D_en), 32'(e_d));
        chk({tag, ".E_flush"}, 32'(E_flush), 32'(e_fl));
        chk({tag, ".exc"}, 32'(pc_sel_exc), 32'(e_x));
        chk({tag, ".epc"}, 32'(pc_sel_epc), 32'(e_p));
        chk({tag, ".excl"}, 32'(pc_sel_exc & pc_sel_epc), 0);
        if (verbose)
            $display("%s: in sd=%0b md=%0b er=%0b st=%0b dv=%0b ir=%0b -> F=%0b D=%0b fl=%0b exc=%0b epc=%0b cnt=%0d stall=%0d",
                     tag, sd, md, er, st, dv, ir, F_en, D_en, E_flush, pc_sel_exc, pc_sel_epc,
                     md_count, stall_cnt);
        if (st && !ir) m_md = dv ? 10 : 5;
        else if (m_md > 0) m_md--;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_md = 0; m_sq = 0; m_cnt = 0;
    endtask

    initial begin
        reset = 1'b1;
        D_stall_data = 1; D_is_md = 0; D_eret = 0; E_md_start = 0; E_md_div = 0; intReq = 0;
        model_reset();
        @(negedge clk);
        chk_reset_outputs("reset");
        $display("reset: stall request held, F=%0b D=%0b fl=%0b cnt=%0d", F_en, D_en, E_flush, stall_cnt);
        @(posedge clk);
        #1 reset = 1'b0;

        // Stall after reset release, then counter visible one edge later
        cycle("rst_stall", 1, 0, 0, 0, 0, 0, 1);
        cycle("rst_after", 0, 0, 0, 0, 0, 0, 1);
        chk("rst_cnt1", 32'(stall_cnt), 1);

        // Multiply: D_is_md held across the busy window
        cycle("mult0", 0, 1, 0, 1, 0, 0, 1);
        for (int i = 1; i <= 5; i++) cycle("mult_busy", 0, 1, 0, 0, 0, 0, 1);
        cycle("mult_done", 0, 1, 0, 0, 0, 0, 1);
        chk("mult_cnt7", 32'(stall_cnt), 7);

        // Divide start suppressed by interrupt, then interrupt during running divide
        cycle("div_int", 0, 0, 0, 1, 1, 1, 1);
        chk("div_int_md0", 32'(md_count), 0);
        cycle("div_start", 0, 0, 0, 1, 1, 0, 1);
        cycle("div_run", 0, 0, 0, 0, 0, 0, 1);
        cycle("div_irq", 0, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 9; i++) cycle("div_drain", 0, 0, 0, 0, 0, 0, 1);
        chk("div_md0", 32'(md_count), 0);

        // ERET: issue, squash slot, back to run
        cycle("eret_n", 0, 0, 1, 0, 0, 0, 1);
        cycle("eret_n1", 0, 0, 0, 0, 0, 0, 1);
        cycle("eret_n2", 0, 0, 0, 0, 0, 0, 1);

        // ERET held behind a data stall, then interrupt in the squash slot
        cycle("eret_st0", 1, 0, 1, 0, 0, 0, 1);
        cycle("eret_st1", 1, 0, 1, 0, 0, 0, 1);
        cycle("eret_go", 0, 0, 1, 0, 0, 0, 1);
        cycle("eret_irq", 1, 0, 0, 0, 0, 1, 1);
        cycle("eret_run", 0, 0, 0, 0, 0, 0, 1);

        // Asynchronous reset in the middle of a divide
        cycle("mid_div", 1, 0, 0, 1, 1, 0, 1);
        cycle("mid_busy", 1, 1, 0, 0, 0, 0, 1);
        D_stall_data = 1; D_is_md = 1;
        reset = 1'b1;
        #1;
        model_reset();
        chk_reset_outputs("mid_reset");
        $display("mid_reset: md_count=%0d stall_cnt=%0d F=%0b", md_count, stall_cnt, F_en);
        @(posedge clk);
        #1 reset = 1'b0;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle("rand", ($urandom_range(3) == 0), ($urandom_range(2) == 0),
                  ($urandom_range(9) == 0), ($urandom_range(9) == 0),
                  1'($urandom_range(1)), ($urandom_range(19) == 0), 1);
        end

        // Saturation: hold a stall well past the counter range
        for (int i = 0; i < CNT_MAX + 4; i++) cycle("sat", 1, 0, 0, 0, 0, 0, 0);
        chk("sat_value", 32'(stall_cnt), 32'(CNT_MAX));
        cycle("sat_hold", 1, 0, 0, 0, 0, 0, 1);
        chk("sat_nowrap", 32'(stall_cnt), 32'(CNT_MAX));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
